// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the temperature digit scanner:
// converter states, display slots, anode patterns and the BCD adjust step.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  typedef enum logic [1:0] {
    SLOT_UNITS    = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2
  } slot_e;

  localparam logic [NUM_DIGITS-1:0] AN_UNITS    = 3'b110;
  localparam logic [NUM_DIGITS-1:0] AN_TENS     = 3'b101;
  localparam logic [NUM_DIGITS-1:0] AN_HUNDREDS = 3'b011;
  localparam logic [NUM_DIGITS-1:0] AN_OFF      = 3'b111;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [NUM_DIGITS*BCD_W-1:0] bcd_adjust(
    input logic [NUM_DIGITS*BCD_W-1:0] bcd
  );
    logic [NUM_DIGITS*BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*BCD_W +: BCD_W] >= 4'd5) begin
        res[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd3;
      end else begin
        res[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, one shift-add-3 step per cycle.
// done pulses in the last CONV cycle with the finished value on bcd.
module bin2bcd_seq
  import seg_scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  iter_q, iter_d;
  logic [19:0] adj_s;

  // Next-state logic for the conversion FSM and its datapath.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    done    = 1'b0;
    adj_s   = {bcd_adjust(acc_q), bin_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = din;
          acc_d   = 12'h000;
          iter_d  = 3'd0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        {acc_d, bin_d} = {adj_s[18:0], 1'b0};
        iter_d         = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CONV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Converter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= 8'h00;
      acc_q   <= 12'h000;
      iter_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

  assign busy = (state_q == CONV);
  assign bcd  = acc_d;

endmodule

// File: rtl/temp_digit_scan.sv
// Temperature display driver: accepts a sample, converts it to BCD and
// time-multiplexes the three digits onto the 7-segment decoder with leading-zero blanking.
module temp_digit_scan
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  temp_valid,
  input  logic [7:0]            temp_data,
  output logic                  temp_ready,
  output logic [BCD_W-1:0]      digit,
  output logic                  dec_cs_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic                  busy_s, done_s, start_s;
  logic [11:0]           bcd_s;
  logic [11:0]           disp_q, disp_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  slot_e                 slot_q, slot_d;
  logic [BCD_W-1:0]      digit_q, digit_d;
  logic                  cs_q, cs_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [BCD_W-1:0]      sel_digit_s;
  logic [NUM_DIGITS-1:0] sel_an_s;
  logic                  lit_s;

  assign temp_ready = ~busy_s;
  assign start_s    = temp_valid & temp_ready;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .din   (temp_data),
    .busy  (busy_s),
    .done  (done_s),
    .bcd   (bcd_s)
  );

  // Display register, refresh counter and slot advance.
  always_comb begin
    disp_d = disp_q;
    rcnt_d = rcnt_q;
    slot_d = slot_q;
    if (done_s) begin
      disp_d = bcd_s;
    end else begin
      disp_d = disp_q;
    end
    if (rcnt_q == CNT_MAX) begin
      rcnt_d = '0;
      case (slot_q)
        SLOT_UNITS:    slot_d = SLOT_TENS;
        SLOT_TENS:     slot_d = SLOT_HUNDREDS;
        SLOT_HUNDREDS: slot_d = SLOT_UNITS;
        default:       slot_d = SLOT_UNITS;
      endcase
    end else begin
      rcnt_d = rcnt_q + CNT_W'(1);
    end
  end

  // Digit select and leading-zero blanking for the current slot.
  always_comb begin
    sel_digit_s = disp_q[3:0];
    sel_an_s    = AN_OFF;
    lit_s       = 1'b0;
    case (slot_q)
      SLOT_UNITS: begin
        sel_digit_s = disp_q[3:0];
        sel_an_s    = AN_UNITS;
        lit_s       = 1'b1;
      end
      SLOT_TENS: begin
        sel_digit_s = disp_q[7:4];
        sel_an_s    = AN_TENS;
        lit_s       = (disp_q[11:4] != 8'h00);
      end
      SLOT_HUNDREDS: begin
        sel_digit_s = disp_q[11:8];
        sel_an_s    = AN_HUNDREDS;
        lit_s       = (disp_q[11:8] != 4'h0);
      end
      default: begin
        sel_digit_s = 4'h0;
        sel_an_s    = AN_OFF;
        lit_s       = 1'b0;
      end
    endcase
    digit_d = sel_digit_s;
    cs_d    = ~lit_s;
    if (lit_s) begin
      an_d = sel_an_s;
    end else begin
      an_d = AN_OFF;
    end
  end

  // Display, scanner and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q  <= 12'h000;
      rcnt_q  <= '0;
      slot_q  <= SLOT_UNITS;
      digit_q <= 4'h0;
      cs_q    <= 1'b1;
      an_q    <= AN_OFF;
    end else begin
      disp_q  <= disp_d;
      rcnt_q  <= rcnt_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      cs_q    <= cs_d;
      an_q    <= an_d;
    end
  end

  assign digit    = digit_q;
  assign dec_cs_n = cs_q;
  assign an_n     = an_q;

endmodule

// File: tb/tb_temp_digit_scan.sv
// Scoreboard bench for temp_digit_scan: stimulus queues expected display windows,
// a monitor compares every cycle of each window against a decimal reference model.
module tb_temp_digit_scan;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       temp_valid = 1'b0;
  logic [7:0] temp_data = 8'h00;
  logic       temp_ready;
  logic [3:0] digit;
  logic       dec_cs_n;
  logic [2:0] an_n;

  always #5 clk = ~clk;

  temp_digit_scan #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst        (rst),
    .temp_valid (temp_valid),
    .temp_data  (temp_data),
    .temp_ready (temp_ready),
    .digit      (digit),
    .dec_cs_n   (dec_cs_n),
    .an_n       (an_n)
  );

  typedef struct {
    int start;
    int n;
    int val;
  } item_t;

  item_t q[$];
  item_t it;
  int    cyc = 0;
  int    esr = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_busy = 1'b0;
  int    cur_disp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges since reset release; sets the expected scan phase.
  always @(posedge clk or posedge rst) begin
    if (rst) esr <= 0;
    else     esr <= esr + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected {digit, dec_cs_n, an_n} for value v, e edges after reset release.
  function automatic logic [7:0] exp_out(input int v, input int e);
    int         h, t, u, s;
    logic       lit;
    logic [3:0] d;
    logic [2:0] pat;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    s = ((e - 1) / RD) % 3;
    case (s)
      0:       begin d = 4'(u); lit = 1'b1;                 pat = 3'b110; end
      1:       begin d = 4'(t); lit = (h != 0) || (t != 0); pat = 3'b101; end
      default: begin d = 4'(h); lit = (h != 0);             pat = 3'b011; end
    endcase
    return {d, ~lit, (lit ? pat : 3'b111)};
  endfunction

  task automatic push(input int start, input int n, input int val);
    item_t x;
    x.start = start;
    x.n     = n;
    x.val   = val;
    q.push_back(x);
  endtask

  // Monitor: compares each cycle of each queued window.
  initial begin
    forever begin
      wait (q.size() > 0);
      mon_busy = 1'b1;
      it = q.pop_front();
      for (int g = 0; g < 2000 && cyc < it.start; g++) @(negedge clk);
      check("window_start", cyc, it.start);
      for (int j = 0; j < it.n; j++) begin
        check("scan", {digit, dec_cs_n, an_n}, exp_out(it.val, esr));
        if (j < it.n - 1) @(negedge clk);
      end
      mon_busy = 1'b0;
    end
  end

  task automatic drain();
    for (int g = 0; g < 5000 && (q.size() != 0 || mon_busy); g++) @(negedge clk);
    check("drain", q.size(), 0);
  endtask

  // Called at a negedge; returns the handshake cycle.
  task automatic send(input int v, input int n, output int t);
    temp_valid = 1'b1;
    temp_data  = 8'(v);
    for (int g = 0; g < 50 && !temp_ready; g++) @(negedge clk);
    check("ready_wait", temp_ready, 1);
    t = cyc + 1;
    push(t + 8, 1, cur_disp);
    push(t + 9, n, v);
    cur_disp = v;
    @(negedge clk);
    temp_valid = 1'b0;
    check("ready_after_accept", temp_ready, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit"}, digit, 4'h0);
    check({tag, "_cs"}, dec_cs_n, 1'b1);
    check({tag, "_an"}, an_n, 3'b111);
    check({tag, "_ready"}, temp_ready, 1'b1);
  endtask

  initial begin
    int t, t2;
    int vals[7] = '{0, 7, 10, 99, 100, 255, 123};

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    push(cyc + 1, 3 * RD, 0);

    foreach (vals[i]) begin
      drain();
      send(vals[i], 6 * RD, t);
    end

    // Reset mid-frame with a sample being offered.
    drain();
    temp_valid = 1'b1;
    temp_data  = 8'd33;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    temp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_disp = 0;
    push(cyc + 1, 3 * RD, 0);

    // Backpressure: 200 offered while 42 converts.
    drain();
    send(42, 8, t);
    temp_valid = 1'b1;
    temp_data  = 8'd200;
    for (int i = 0; i < 8; i++) begin
      check("bp_ready_low", temp_ready, 0);
      @(negedge clk);
    end
    send(200, 3 * RD, t2);
    check("bp_accept_cycle", t2, t + 9);

    // Reset four cycles into a conversion of 188: no commit.
    drain();
    temp_valid = 1'b1;
    temp_data  = 8'd188;
    @(negedge clk);
    temp_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("conv_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_disp = 0;
    push(cyc + 1, 16, 0);
    drain();
    send(61, 3 * RD, t);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
